// File: rtl/data_mem_ctrl.sv
// Data-memory controller: a word array with byte/half/word loads and stores and WAIT_CYCLES wait states.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being force-aligned.
module data_mem_ctrl #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        fault
);
    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        rd_q, wr_q;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  funct3_q;
    logic [31:0] mem [DEPTH];

    logic        req, enter_resp;
    logic        cur_rd, cur_wr;
    logic [31:0] cur_addr, cur_wdata;
    logic [2:0]  cur_f3;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] wlane, rword, load_val;
    logic [29:0] widx;
    logic        f3_bad, misalign, oob, acc_fault;

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        sb = w[7:0];
        sh = w[15:0];
        case (f)
            3'b000:  return 32'(sb);
            3'b001:  return 32'(sh);
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign req = MemRead | MemWrite;

    // In IDLE the access is still on the inputs (zero-wait case); afterwards use the captured copy.
    always_comb begin
        if (state == IDLE) begin
            cur_rd    = MemRead;
            cur_wr    = MemWrite;
            cur_addr  = addr;
            cur_wdata = wdata;
            cur_f3    = funct3;
        end else begin
            cur_rd    = rd_q;
            cur_wr    = wr_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_f3    = funct3_q;
        end
    end

    always_comb begin
        off   = 2'b00;
        be    = 4'b0000;
        wlane = cur_wdata;
        case (cur_f3[1:0])
            2'b00: begin
                off   = cur_addr[1:0];
                be    = 4'b0001 << off;
                wlane = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                off   = {cur_addr[1], 1'b0};
                be    = 4'b0011 << off;
                wlane = {2{cur_wdata[15:0]}};
            end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        f3_bad = (cur_f3 == 3'b011) || (cur_f3 == 3'b110) || (cur_f3 == 3'b111);
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                   ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        widx      = cur_addr[31:2];
        oob       = widx >= 30'(DEPTH);
        acc_fault = (cur_rd & cur_wr) | oob | f3_bad | misalign;
        rword     = mem[widx[AW-1:0]];
        load_val  = load_ext(rword >> {off, 3'b000}, cur_f3);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT: if (cnt == 4'd0) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        enter_resp = (state != RESP) && (state_nxt == RESP);
        stall      = rst_n && (((state == IDLE) && req) || (state == WAIT));
    end

    // Array is never reset; a store commits only on a clean, non-faulting entry into RESP.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && cur_wr && !acc_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx[AW-1:0]][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            rdata    <= 32'd0;
            done     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && req) begin
                rd_q     <= MemRead;
                wr_q     <= MemWrite;
                addr_q   <= addr;
                wdata_q  <= wdata;
                funct3_q <= funct3;
            end
            if ((state == IDLE) && (state_nxt == WAIT)) cnt <= CNT_INIT;
            else if ((state == WAIT) && (cnt != 4'd0)) cnt <= cnt - 4'd1;
            done  <= enter_resp;
            fault <= enter_resp & acc_fault;
            if (enter_resp && cur_rd) rdata <= acc_fault ? 32'd0 : load_val;
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with 2 wait states, one with none.
module tb_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        mr, mw;
    logic [31:0] ad, wd;
    logic [2:0]  f3;
    logic [31:0] rdata2, rdata0;
    logic        stall2, stall0, done2, done0, fault2, fault0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(mr & ~sel), .MemWrite(mw & ~sel),
        .addr(ad), .wdata(wd), .funct3(f3),
        .rdata(rdata2), .stall(stall2), .done(done2), .fault(fault2)
    );

    data_mem_ctrl #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .MemRead(mr & sel), .MemWrite(mw & sel),
        .addr(ad), .wdata(wd), .funct3(f3),
        .rdata(rdata0), .stall(stall0), .done(done0), .fault(fault0)
    );

    function automatic logic [31:0] o_rdata();
        return sel ? rdata0 : rdata2;
    endfunction
    function automatic logic o_stall();
        return sel ? stall0 : stall2;
    endfunction
    function automatic logic o_done();
        return sel ? done0 : done2;
    endfunction
    function automatic logic o_fault();
        return sel ? fault0 : fault2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One access; returns rdata/fault seen in the done cycle. hold keeps the request up through RESP.
    task automatic acc(input logic s, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f, input int lat, input logic hold,
                       output logic [31:0] q, output logic flt);
        int n;
        @(posedge clk); #1;
        sel = s;
        chk("done_clr", {31'd0, o_done()}, 32'd0);
        mr = r; mw = w; ad = a; wd = d; f3 = f;
        #1;
        chk("stall_req", {31'd0, o_stall()}, 32'd1);
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (o_done()) break;
            if (n < lat) chk("stall_wait", {31'd0, o_stall()}, 32'd1);
        end
        chk("latency", 32'(n), 32'(lat));
        chk("stall_resp", {31'd0, o_stall()}, 32'd0);
        q   = o_rdata();
        flt = o_fault();
        if (!hold) begin
            mr = 1'b0;
            mw = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] q;
        logic        flt;
        rst_n = 1'b0; sel = 1'b0; mr = 1'b1; mw = 1'b0; ad = 32'd0; wd = 32'd0; f3 = 3'b010;
        #3;
        chk("rst_stall", {31'd0, stall2}, 32'd0);
        chk("rst_done", {31'd0, done2}, 32'd0);
        chk("rst_fault", {31'd0, fault2}, 32'd0);
        chk("rst_rdata", rdata2, 32'd0);
        repeat (2) @(posedge clk);
        #1; mr = 1'b0; rst_n = 1'b1;

        acc(0, 0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 3, 0, q, flt);
        chk("sw_fault", {31'd0, flt}, 32'd0);
        acc(0, 1, 0, 32'h10, 32'd0, 3'b010, 3, 0, q, flt);
        chk("lw", q, 32'hDEADBEEF);
        chk("lw_fault", {31'd0, flt}, 32'd0);
        acc(0, 1, 0, 32'h13, 32'd0, 3'b000, 3, 0, q, flt);
        chk("lb", q, 32'hFFFFFFDE);
        acc(0, 1, 0, 32'h13, 32'd0, 3'b100, 3, 0, q, flt);
        chk("lbu", q, 32'h000000DE);
        acc(0, 0, 1, 32'h11, 32'h00000055, 3'b000, 3, 0, q, flt);
        chk("rdata_hold", q, 32'h000000DE);
        acc(0, 1, 0, 32'h10, 32'd0, 3'b010, 3, 0, q, flt);
        chk("sb_merge", q, 32'hDEAD55EF);
        acc(0, 1, 0, 32'h12, 32'd0, 3'b001, 3, 0, q, flt);
        chk("lh", q, 32'hFFFFDEAD);
        acc(0, 1, 0, 32'h12, 32'd0, 3'b101, 3, 0, q, flt);
        chk("lhu", q, 32'h0000DEAD);
        acc(0, 0, 1, 32'h14, 32'h11223344, 3'b010, 3, 0, q, flt);
        acc(0, 0, 1, 32'h16, 32'hAAAA8001, 3'b001, 3, 0, q, flt);
        acc(0, 1, 0, 32'h14, 32'd0, 3'b010, 3, 0, q, flt);
        chk("sh_merge", q, 32'h80013344);

        acc(0, 0, 1, 32'h0, 32'h0BADF00D, 3'b010, 3, 0, q, flt);
        acc(0, 1, 1, 32'h0, 32'hFFFFFFFF, 3'b010, 3, 0, q, flt);
        chk("both_fault", {31'd0, flt}, 32'd1);
        acc(0, 1, 0, 32'h0, 32'd0, 3'b010, 3, 0, q, flt);
        chk("both_nowrite", q, 32'h0BADF00D);
        acc(0, 1, 0, 32'h100, 32'd0, 3'b010, 3, 0, q, flt);
        chk("oob_ld_fault", {31'd0, flt}, 32'd1);
        chk("oob_ld_rdata", q, 32'd0);
        acc(0, 0, 1, 32'h100, 32'hFFFFFFFF, 3'b010, 3, 0, q, flt);
        chk("oob_st_fault", {31'd0, flt}, 32'd1);
        acc(0, 1, 0, 32'h3, 32'd0, 3'b011, 3, 0, q, flt);
        chk("f3_011_fault", {31'd0, flt}, 32'd1);
        acc(0, 0, 1, 32'h0, 32'd0, 3'b110, 3, 0, q, flt);
        chk("f3_110_fault", {31'd0, flt}, 32'd1);
        acc(0, 1, 0, 32'h0, 32'd0, 3'b010, 3, 0, q, flt);
        chk("word0_intact", q, 32'h0BADF00D);

        acc(0, 1, 0, 32'h10, 32'd0, 3'b010, 3, 1, q, flt);
        chk("held_first", q, 32'hDEAD55EF);
        acc(0, 1, 0, 32'h10, 32'd0, 3'b010, 3, 0, q, flt);
        chk("held_second", q, 32'hDEAD55EF);

        acc(0, 0, 1, 32'h20, 32'hCAFEF00D, 3'b010, 3, 0, q, flt);
        acc(0, 1, 0, 32'h20, 32'd0, 3'b010, 3, 0, q, flt);
        chk("lw_20", q, 32'hCAFEF00D);

        @(posedge clk); #1;
        mw = 1'b1; ad = 32'h20; wd = 32'h12345678; f3 = 3'b010;
        @(posedge clk); #1;
        chk("pre_rst_stall", {31'd0, stall2}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_stall", {31'd0, stall2}, 32'd0);
        chk("arst_done", {31'd0, done2}, 32'd0);
        chk("arst_fault", {31'd0, fault2}, 32'd0);
        chk("arst_rdata", rdata2, 32'd0);
        mw = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_done_post_rst", {31'd0, done2}, 32'd0);
        end
        acc(0, 1, 0, 32'h20, 32'd0, 3'b010, 3, 0, q, flt);
        chk("rst_abandon", q, 32'hCAFEF00D);

`ifdef DMEM_MISALIGN_TRAP_EN
        acc(0, 1, 0, 32'h22, 32'd0, 3'b010, 3, 0, q, flt);
        chk("mis_lw_fault", {31'd0, flt}, 32'd1);
        acc(0, 1, 0, 32'h23, 32'd0, 3'b101, 3, 0, q, flt);
        chk("mis_lh_fault", {31'd0, flt}, 32'd1);
`else
        acc(0, 1, 0, 32'h22, 32'd0, 3'b010, 3, 0, q, flt);
        chk("mis_lw", q, 32'hCAFEF00D);
        chk("mis_lw_fault", {31'd0, flt}, 32'd0);
        acc(0, 1, 0, 32'h23, 32'd0, 3'b101, 3, 0, q, flt);
        chk("mis_lhu", q, 32'h0000CAFE);
`endif

        acc(1, 0, 1, 32'h8, 32'h01020304, 3'b010, 1, 0, q, flt);
        chk("w0_sw_fault", {31'd0, flt}, 32'd0);
        acc(1, 1, 0, 32'h8, 32'd0, 3'b010, 1, 0, q, flt);
        chk("w0_lw", q, 32'h01020304);
        acc(1, 1, 0, 32'hB, 32'd0, 3'b100, 1, 0, q, flt);
        chk("w0_lbu", q, 32'h00000001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
